// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder slice.
//   ADDER_WIDTH : default operand / sum width
//   COUNT_W     : width of the delivered-result counter
//   operand_t   : {a, b, cin} beat at the default width
//   result_t    : {cout, sum} beat at the default width
package adder_pkg;

  localparam int ADDER_WIDTH = 4;
  localparam int COUNT_W     = 16;

  typedef struct packed {
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   cin;
  } operand_t;

  typedef struct packed {
    logic                   cout;
    logic [ADDER_WIDTH-1:0] sum;
  } result_t;

endpackage

// File: rtl/adder_if.sv
// Operand and result channels of the pipelined adder, each with valid/ready.
//   master : the environment side (drives operands, consumes results)
//   slave  : the adder side (accepts operands, presents results and count)
interface adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cin;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [COUNT_W-1:0] result_count;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, result_count
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, result_count
  );

endinterface

// File: rtl/adder_stage.sv
// Generic valid/ready pipeline register, payload type given by parameter T.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload (from flops)
// The stage loads whenever it is empty or its contents leave on the same
// edge, so an empty stage pulls a bubble or a beat regardless of out_ready.
module adder_stage #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic vld;
  T     data;
  logic load_ok;

  // Combinational ready: ripples straight through from out_ready.
  assign load_ok   = !vld || out_ready;
  assign in_ready  = load_ok;
  assign out_valid = vld;
  assign out_data  = data;

  // Payload is cleared on reset so the downstream outputs read zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (load_ok) begin
      vld <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Two-stage pipelined WIDTH-bit adder with carry-in/carry-out.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : operand channel (in_valid/in_ready, a, b, cin),
//                result channel (out_valid/out_ready, sum, cout),
//                result_count (saturating count of delivered results)
// Stage 1 registers the operands; the add is done between the stages and
// stage 2 registers {cout, sum}, so all result outputs come from flops.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input logic   clk,
  input logic   reset,
  adder_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } opnd_t;

  typedef struct packed {
    logic             cout;
    logic [WIDTH-1:0] sum;
  } res_t;

  function automatic res_t add_operands(input opnd_t op);
    logic [WIDTH:0] total;
    total = {1'b0, op.a} + {1'b0, op.b} + {{WIDTH{1'b0}}, op.cin};
    return res_t'(total);
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (c == {COUNT_W{1'b1}}) ? c : c + COUNT_W'(1);
  endfunction

  opnd_t              opnd_p0;
  opnd_t              opnd_p1;
  logic               vld_p1;
  logic               s2_ready;
  res_t               res_p1;
  res_t               res_p2;
  logic               vld_p2;
  logic [COUNT_W-1:0] count;

  assign opnd_p0 = '{a: bus.a, b: bus.b, cin: bus.cin};

  // ---- stage 1: operand register ----
  adder_stage #(.T(opnd_t)) u_stage1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (opnd_p0),
    .out_valid (vld_p1),
    .out_ready (s2_ready),
    .out_data  (opnd_p1)
  );

  assign res_p1 = add_operands(opnd_p1);

  // ---- stage 2: result register ----
  adder_stage #(.T(res_t)) u_stage2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (vld_p1),
    .in_ready  (s2_ready),
    .in_data   (res_p1),
    .out_valid (vld_p2),
    .out_ready (bus.out_ready),
    .out_data  (res_p2)
  );

  assign bus.out_valid = vld_p2;
  assign bus.sum       = res_p2.sum;
  assign bus.cout      = res_p2.cout;

  // ---- output side: delivered-result counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (vld_p2 && bus.out_ready) begin
      count <= sat_inc(count);
    end
  end

  assign bus.result_count = count;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed sequences plus random
// traffic, with a queue-based scoreboard fed on every input transfer and
// drained by a monitor on every output transfer.
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int           exp_q[$];
  logic [15:0]  model_count = 16'd0;
  logic         stall_prev  = 1'b0;
  logic [W:0]   held        = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_count = 16'd0;
      stall_prev  = 1'b0;
    end else begin
      checks++;
      if (bus.result_count !== model_count) begin
        errors++;
        $display("FAIL result_count: got %0d expected %0d", bus.result_count, model_count);
      end
      if (stall_prev) begin
        checks++;
        if (!bus.out_valid || {bus.cout, bus.sum} !== held) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b res=%0h expected valid=1 res=%0h",
                   bus.out_valid, {bus.cout, bus.sum}, held);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got res=%0h expected no output", {bus.cout, bus.sum});
        end else begin
          int e;
          e = exp_q.pop_front();
          if ({bus.cout, bus.sum} !== e[W:0]) begin
            errors++;
            $display("FAIL result: got cout=%0b sum=%0h expected cout=%0b sum=%0h",
                     bus.cout, bus.sum, e[W], e[W-1:0]);
          end
        end
        if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = {bus.cout, bus.sum};
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(int'(bus.a) + int'(bus.b) + int'(bus.cin));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_count", bus.result_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    reset = 1'b0;

    // Basic add with latency check.
    bus.a = 4'h3; bus.b = 4'h4; bus.cin = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("lat_not_yet", bus.out_valid, 0);
    tick();
    chk("lat_valid", bus.out_valid, 1);
    chk("basic_sum", bus.sum, 7);
    chk("basic_cout", bus.cout, 0);
    tick();
    chk("basic_count", bus.result_count, 1);

    // Carry / wrap cases.
    bus.a = 4'hF; bus.b = 4'h1; bus.cin = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.a = 4'hF; bus.b = 4'hF; bus.cin = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("wrap1_sum", bus.sum, 1);
    chk("wrap1_cout", bus.cout, 1);
    tick();
    chk("wrap2_sum", bus.sum, 15);
    chk("wrap2_cout", bus.cout, 1);
    drain(10);

    // Back-pressure: two beats buffered, third refused.
    bus.out_ready = 1'b0;
    bus.cin = 1'b0;
    bus.a = 4'h1; bus.b = 4'h1; bus.in_valid = 1'b1;
    chk("bp_ready1", bus.in_ready, 1);
    tick();
    bus.a = 4'h2; bus.b = 4'h2;
    chk("bp_ready2", bus.in_ready, 1);
    tick();
    bus.a = 4'h3; bus.b = 4'h3;
    chk("bp_ready3_low", bus.in_ready, 0);
    chk("bp_head_sum", bus.sum, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_ready", bus.in_ready, 0);
      chk("bp_stall_sum", bus.sum, 2);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_ripple", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_second_sum", bus.sum, 4);
    tick();
    chk("bp_third_sum", bus.sum, 6);
    drain(10);

    // Streaming 16 beats from a fresh reset.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      bus.in_valid = 1'b1;
      chk("stream_ready", bus.in_ready, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    drain(10);
    chk("stream_count", bus.result_count, 16);

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 4'h5; bus.b = 4'h6; bus.cin = 1'b0;
    tick();
    tick();
    bus.in_valid = 1'b0;
    chk("full_valid", bus.out_valid, 1);
    do_reset();
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_count", bus.result_count, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("no_stale", bus.out_valid, 0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain(10);

    // Saturation of the delivered-result counter.
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 65545; i++) begin
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      tick();
    end
    drain(10);
    chk("sat_count", bus.result_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
